// File: rtl/ysyx_220066_fetch_queue_pkg.sv
// Shared definitions for the fetch front end: default widths, reset PC and
// the packing width of one queued fetch entry {pc, instr, fault}.
package ysyx_220066_fetch_queue_pkg;

  localparam int          DEF_XLEN     = 64;
  localparam logic [63:0] DEF_RESET_PC = 64'h8000_0000;
  localparam int          INSTR_W      = 32;
  localparam int          FETCH_STRIDE = 4;

  // One entry carries the fetch PC, the instruction word and the fault bit.
  function automatic int entry_width(input int xlen);
    return xlen + INSTR_W + 1;
  endfunction

endpackage

// File: rtl/ysyx_220066_fetch_queue_fifo.sv
// Synchronous FIFO with wrap-around pointers and a separate occupancy counter.
// The head word is read straight from storage so it is visible the cycle after a push.
module ysyx_220066_sync_fifo #(
  parameter int WIDTH = 97,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign count = count_reg;
  assign rdata = mem[rd_ptr_reg];

  // A push into a full queue only lands when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (do_push && !do_pop)      count_reg <= count_reg + 1'b1;
      else if (do_pop && !do_push) count_reg <= count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem[wr_ptr_reg] <= wdata;
  end

endmodule

// File: rtl/ysyx_220066_fetch_queue.sv
// Instruction-fetch front end: sequential PC generation, fault halting and
// redirect handling in front of a decoupling queue toward decode.
module ysyx_220066_fetch_queue
  import ysyx_220066_fetch_queue_pkg::*;
#(
  parameter int              XLEN     = DEF_XLEN,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC)
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [XLEN-1:0]          pc_rd,
  output logic                     req_valid,
  input  logic [INSTR_W-1:0]       instr_rd,
  input  logic                     instr_valid,
  input  logic                     instr_error,
  input  logic                     is_jmp,
  input  logic [XLEN-1:0]          nxtpc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [INSTR_W-1:0]       out_instr,
  output logic                     out_error,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int EW = entry_width(XLEN);

  logic [XLEN-1:0] pc_reg;
  logic            halted_reg;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic [EW-1:0]   wdata;
  logic [EW-1:0]   rdata;

  assign pop       = out_valid && out_ready;
  // A full queue still accepts a fetch when decode drains the head this cycle.
  assign req_valid = !rst && !halted_reg && (!full || pop);
  assign push      = req_valid && instr_valid && !is_jmp;
  assign pc_rd     = pc_reg;
  assign out_valid = !empty;
  assign wdata     = {pc_reg, instr_rd, instr_error};
  assign {out_pc, out_instr, out_error} = rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg     <= RESET_PC;
      halted_reg <= 1'b0;
    end else if (is_jmp) begin
      pc_reg     <= nxtpc;
      halted_reg <= 1'b0;
    end else if (push) begin
      pc_reg <= pc_reg + XLEN'(FETCH_STRIDE);
      // A faulting fetch is still delivered; nothing after it is fetched.
      if (instr_error) halted_reg <= 1'b1;
    end
  end

  ysyx_220066_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (is_jmp),
    .wdata (wdata),
    .rdata (rdata),
    .count (count),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_ysyx_220066_fetch_queue.sv
// Directed and randomized bench for the fetch queue against a queue-based model.
module tb_ysyx_220066_fetch_queue;

  localparam int          XLEN  = 64;
  localparam int          DEPTH = 4;
  localparam logic [63:0] RPC   = 64'h8000_0000;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        err;
  } ent_t;

  logic        clk;
  logic        rst;
  logic [63:0] pc_rd;
  logic        req_valid;
  logic [31:0] instr_rd;
  logic        instr_valid;
  logic        instr_error;
  logic        is_jmp;
  logic [63:0] nxtpc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_error;
  logic [2:0]  count;

  ent_t        m_q[$];
  logic [63:0] m_pc;
  logic        m_halted;
  int          n_cmp;
  int          n_bad;

  ysyx_220066_fetch_queue #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .RESET_PC (RPC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_rd       (pc_rd),
    .req_valid   (req_valid),
    .instr_rd    (instr_rd),
    .instr_valid (instr_valid),
    .instr_error (instr_error),
    .is_jmp      (is_jmp),
    .nxtpc       (nxtpc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_instr   (out_instr),
    .out_error   (out_error),
    .count       (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic model_req();
    return !rst && !m_halted &&
           (m_q.size() < DEPTH || (m_q.size() > 0 && out_ready));
  endfunction

  task automatic check_model(input string ph);
    chk({ph, ":pc_rd"},     pc_rd,     m_pc);
    chk({ph, ":req_valid"}, 64'(req_valid), 64'(model_req()));
    chk({ph, ":out_valid"}, 64'(out_valid), 64'(m_q.size() > 0));
    chk({ph, ":count"},     64'(count),     64'(m_q.size()));
    chk({ph, ":count_max"}, 64'(count <= DEPTH), 64'(1));
    if (m_q.size() > 0) begin
      chk({ph, ":out_pc"},    out_pc,            m_q[0].pc);
      chk({ph, ":out_instr"}, 64'(out_instr),    64'(m_q[0].instr));
      chk({ph, ":out_error"}, 64'(out_error),    64'(m_q[0].err));
    end
  endtask

  // Advance the model by one clock using the inputs held across the edge.
  task automatic update_model();
    logic do_pop;
    logic do_push;
    ent_t e;
    if (rst) begin
      m_q.delete();
      m_pc     = RPC;
      m_halted = 1'b0;
    end else begin
      do_pop  = m_q.size() > 0 && out_ready;
      do_push = model_req() && instr_valid && !is_jmp;
      if (is_jmp) begin
        m_q.delete();
        m_pc     = nxtpc;
        m_halted = 1'b0;
      end else begin
        if (do_pop) void'(m_q.pop_front());
        if (do_push) begin
          e.pc = m_pc; e.instr = instr_rd; e.err = instr_error;
          m_q.push_back(e);
          if (instr_error) m_halted = 1'b1;
          m_pc = m_pc + 64'd4;
        end
      end
    end
  endtask

  // Inputs are set at the falling edge; outputs checked 1ns later.
  task automatic cyc(input string ph);
    #1 check_model(ph);
    @(posedge clk);
    update_model();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; is_jmp = 1'b0; instr_valid = 1'b0; out_ready = 1'b0;
    instr_error = 1'b0;
    cyc("rst");
    cyc("rst");
    rst = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; instr_rd = '0; instr_valid = 1'b0; instr_error = 1'b0;
    is_jmp = 1'b0; nxtpc = '0; out_ready = 1'b0;
    m_q.delete(); m_pc = RPC; m_halted = 1'b0;
    @(negedge clk);

    // Reset state.
    do_reset();
    #1;
    chk("reset_pc", pc_rd, RPC);
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);

    // Streaming with decode always ready: occupancy settles at one.
    instr_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      instr_rd = $urandom;
      cyc("stream");
    end
    #1;
    chk("stream_count", 64'(count), 64'd1);
    chk("stream_pc", pc_rd, RPC + 64'd24);

    // Stall fills the queue, then one pop and one push together.
    do_reset();
    instr_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      instr_rd = $urandom;
      cyc("fill");
    end
    #1;
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_req", 64'(req_valid), 64'd0);
    chk("fill_pc", pc_rd, 64'h8000_0010);
    out_ready = 1'b1;
    #1;
    chk("pass_req", 64'(req_valid), 64'd1);
    cyc("pass");
    chk("pass_count", 64'(count), 64'd4);

    // Third response faults: fetch halts at 8000000C until a redirect.
    do_reset();
    instr_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      instr_rd = $urandom; instr_error = (i == 2);
      cyc("fault");
    end
    instr_error = 1'b0;
    cyc("halted");
    cyc("halted");
    #1;
    chk("halt_pc", pc_rd, 64'h8000_000C);
    chk("halt_req", 64'(req_valid), 64'd0);
    chk("halt_count", 64'(count), 64'd3);
    out_ready = 1'b1; instr_valid = 1'b0;
    cyc("drain");
    cyc("drain");
    #1;
    chk("fault_head_pc", out_pc, 64'h8000_0008);
    chk("fault_head_err", 64'(out_error), 64'd1);
    is_jmp = 1'b1; nxtpc = 64'h8000_0100;
    cyc("redir");
    is_jmp = 1'b0; instr_valid = 1'b1;
    #1;
    chk("resume_pc", pc_rd, 64'h8000_0100);
    chk("resume_req", 64'(req_valid), 64'd1);
    cyc("resume");
    cyc("resume");

    // Redirect with a response and a pop in the same cycle.
    do_reset();
    instr_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      instr_rd = $urandom;
      cyc("pre_jmp");
    end
    out_ready = 1'b1; is_jmp = 1'b1; nxtpc = 64'h8000_0200;
    cyc("jmp");
    is_jmp = 1'b0; instr_valid = 1'b0;
    #1;
    chk("jmp_count", 64'(count), 64'd0);
    chk("jmp_pc", pc_rd, 64'h8000_0200);
    chk("jmp_out_valid", 64'(out_valid), 64'd0);

    // Randomized traffic with occasional faults and redirects.
    for (int i = 0; i < 3000; i++) begin
      instr_valid = $urandom_range(0, 1) != 0;
      out_ready   = $urandom_range(0, 3) != 0;
      instr_rd    = $urandom;
      instr_error = $urandom_range(0, 149) == 0;
      is_jmp      = $urandom_range(0, 39) == 0;
      nxtpc       = {32'h8000_0000, $urandom} & ~64'(($urandom_range(0, 7) != 0) ? 3 : 0);
      cyc("rand");
    end

    // Reset mid-operation with three queued entries.
    is_jmp = 1'b1; nxtpc = 64'h8000_1000; instr_valid = 1'b0; instr_error = 1'b0;
    cyc("rst_prep");
    is_jmp = 1'b0; instr_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      instr_rd = $urandom;
      cyc("rst_fill");
    end
    #1;
    chk("midrst_count_before", 64'(count), 64'd3);
    rst = 1'b1;
    cyc("midrst");
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_count", 64'(count), 64'd0);
    chk("midrst_pc", pc_rd, RPC);
    chk("midrst_req", 64'(req_valid), 64'd0);
    rst = 1'b0;
    #1 cyc("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
